// File: rtl/atm_balance_sequencer.sv
// atm_balance_sequencer
// Sequences deposit / withdraw / inquiry requests against the account balance.
// The balance register lives here. Arithmetic goes through an external N-bit
// adder that has no carry in or carry out. A withdraw first negates the amount
// through the adder, then adds it to the balance. The response is held on a
// valid/ready handshake until the consumer accepts it.
module atm_balance_sequencer #(
    parameter int             N            = 10,
    parameter logic [N-1:0]   INIT_BALANCE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [N-1:0] req_amount,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [1:0]   resp_status,
    output logic [N-1:0] resp_balance,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    input  logic [N-1:0] add_sum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NEG  = 2'd1,
        ADD  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] OP_DEPOSIT  = 2'b00;
    localparam logic [1:0] OP_WITHDRAW = 2'b01;
    localparam logic [1:0] OP_INQUIRY  = 2'b10;

    localparam logic [1:0] ST_OK           = 2'b00;
    localparam logic [1:0] ST_INSUFFICIENT = 2'b01;
    localparam logic [1:0] ST_OVERFLOW     = 2'b10;
    localparam logic [1:0] ST_BAD_OP       = 2'b11;

    state_t       state;
    logic [N-1:0] balance;
    logic [N-1:0] amt;
    logic [N-1:0] opnd;
    logic [1:0]   op;

    // Only IDLE can take a new request.
    assign req_ready = (state == IDLE);

    // Route adder operands for the negate and add passes; idle the adder otherwise.
    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned and infers a latch.
        add_a = '0;
        add_b = '0;
        case (state)
            NEG: begin
                add_a = ~amt;
                add_b = {{(N-1){1'b0}}, 1'b1};
            end
            ADD: begin
                add_a = balance;
                add_b = opnd;
            end
            default: ;
        endcase
    end

    // Transaction FSM: owns the balance, the captured request and the registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, like real flops.
            state        <= IDLE;
            balance      <= INIT_BALANCE;
            amt          <= '0;
            opnd         <= '0;
            op           <= OP_DEPOSIT;
            resp_valid   <= 1'b0;
            resp_status  <= ST_OK;
            resp_balance <= INIT_BALANCE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        amt <= req_amount;
                        op  <= req_op;
                        case (req_op)
                            OP_DEPOSIT: begin
                                opnd  <= req_amount;
                                state <= ADD;
                            end
                            OP_WITHDRAW: begin
                                if (req_amount > balance) begin
                                    // Rejected up front, so the adder never sees an underflow.
                                    resp_status  <= ST_INSUFFICIENT;
                                    resp_balance <= balance;
                                    resp_valid   <= 1'b1;
                                    state        <= RESP;
                                end else begin
                                    state <= NEG;
                                end
                            end
                            OP_INQUIRY: begin
                                resp_status  <= ST_OK;
                                resp_balance <= balance;
                                resp_valid   <= 1'b1;
                                state        <= RESP;
                            end
                            default: begin
                                resp_status  <= ST_BAD_OP;
                                resp_balance <= balance;
                                resp_valid   <= 1'b1;
                                state        <= RESP;
                            end
                        endcase
                    end
                end
                NEG: begin
                    // ~amt + 1 is the two's-complement negation of the withdraw amount.
                    opnd  <= add_sum;
                    state <= ADD;
                end
                ADD: begin
                    // A wrapped deposit shows up as a sum below the old balance.
                    if (op == OP_DEPOSIT && add_sum < balance) begin
                        resp_status  <= ST_OVERFLOW;
                        resp_balance <= balance;
                    end else begin
                        balance      <= add_sum;
                        resp_status  <= ST_OK;
                        resp_balance <= add_sum;
                    end
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_balance_sequencer.sv
// tb_atm_balance_sequencer
// Drives requests into the sequencer and models the external adder. Expected
// responses are pushed to a scoreboard queue as each request is accepted. A
// monitor pops the queue and compares on every response handshake.
module tb_atm_balance_sequencer;

    localparam int N = 10;
    localparam logic [N-1:0] INIT = 10'd100;

    localparam logic [1:0] DEP = 2'b00;
    localparam logic [1:0] WDR = 2'b01;
    localparam logic [1:0] INQ = 2'b10;
    localparam logic [1:0] BAD = 2'b11;

    typedef struct {
        logic [1:0]   status;
        logic [N-1:0] balance;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [N-1:0] req_amount;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_status;
    logic [N-1:0] resp_balance;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic [N-1:0] add_sum;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    int   model_balance;

    always #5 clk = ~clk;

    // External N-bit adder: no carry in, carry out discarded.
    assign add_sum = add_a + add_b;

    atm_balance_sequencer #(.N(N), .INIT_BALANCE(INIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_amount   (req_amount),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_status  (resp_status),
        .resp_balance (resp_balance),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_sum      (add_sum)
    );

    // Reference model: expected status, new balance and latency for one request.
    task automatic model_req(input logic [1:0] op, input int amount,
                             output logic [1:0] st, output int lat);
        case (op)
            DEP: begin
                lat = 2;
                if (model_balance + amount > 1023) st = 2'b10;
                else begin st = 2'b00; model_balance = model_balance + amount; end
            end
            WDR: begin
                if (amount > model_balance) begin st = 2'b01; lat = 1; end
                else begin st = 2'b00; lat = 3; model_balance = model_balance - amount; end
            end
            INQ:     begin st = 2'b00; lat = 1; end
            default: begin st = 2'b11; lat = 1; end
        endcase
    endtask

    // Wait for req_ready, present one request for a single accept edge.
    task automatic send_req(input logic [1:0] op, input int amount, input bit push,
                            output int exp_lat);
        int   k;
        exp_t e;
        logic [1:0] st;
        k = 0;
        while (!req_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL req_ready_timeout: req_ready=%b required 1", req_ready);
        end
        req_valid  = 1'b1;
        req_op     = op;
        req_amount = amount[N-1:0];
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (push) begin
            model_req(op, amount, st, exp_lat);
            e.status  = st;
            e.balance = model_balance[N-1:0];
            sb.push_back(e);
        end else begin
            exp_lat = 0;
        end
    endtask

    // Measure cycles from the accept edge to resp_valid, then let the handshake complete.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (resp_valid && resp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard monitor: compares at the negedge before each handshake edge.
    task automatic run_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid && resp_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL resp_unexpected: status=%b balance=%0d required no response",
                             resp_status, resp_balance);
                end else begin
                    e = sb.pop_front();
                    if (resp_status !== e.status || resp_balance !== e.balance) begin
                        miscompares++;
                        $display("FAIL resp_data: status=%b balance=%0d required status=%b balance=%0d",
                                 resp_status, resp_balance, e.status, e.balance);
                    end
                end
            end
        end
    endtask

    task automatic do_req(input string name, input logic [1:0] op, input int amount);
        int exp_lat, lat;
        send_req(op, amount, 1'b1, exp_lat);
        wait_resp(lat);
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d cycles required %0d", name, lat, exp_lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_balance = 100;
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_status !== 2'b00 ||
            resp_balance !== INIT || add_a !== '0 || add_b !== '0) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b vld=%b st=%b bal=%0d a=%0d b=%0d required 1 0 00 100 0 0",
                     req_ready, resp_valid, resp_status, resp_balance, add_a, add_b);
        end
    endtask

    task automatic test_inquiry();
        int exp_lat, lat;
        send_req(INQ, 0, 1'b1, exp_lat);
        vectors++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL inquiry_after_accept: rdy=%b vld=%b required 0 1", req_ready, resp_valid);
        end
        wait_resp(lat);
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL inquiry_latency: got %0d required %0d", lat, exp_lat);
        end
    endtask

    task automatic test_deposit_withdraw();
        int exp_lat, lat;
        logic [N-1:0] neg_a;
        do_req("deposit_250", DEP, 250);
        send_req(WDR, 350, 1'b1, exp_lat);
        neg_a = ~10'd350;
        vectors++;
        if (add_a !== neg_a || add_b !== 10'd1) begin
            miscompares++;
            $display("FAIL withdraw_neg_operands: a=%0d b=%0d required a=%0d b=1", add_a, add_b, neg_a);
        end
        wait_resp(lat);
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL withdraw_latency: got %0d required %0d", lat, exp_lat);
        end
    endtask

    task automatic test_overflow();
        do_req("deposit_1000", DEP, 1000);
        do_req("deposit_24_ovf", DEP, 24);
        do_req("deposit_23_max", DEP, 23);
        do_req("deposit_0", DEP, 0);
    endtask

    task automatic test_insufficient();
        int exp_lat, lat;
        do_req("withdraw_973", WDR, 973);
        send_req(WDR, 51, 1'b1, exp_lat);
        vectors++;
        if (resp_valid !== 1'b1 || add_a !== '0 || add_b !== '0) begin
            miscompares++;
            $display("FAIL insufficient_no_adder: vld=%b a=%0d b=%0d required 1 0 0", resp_valid, add_a, add_b);
        end
        wait_resp(lat);
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL insufficient_latency: got %0d required %0d", lat, exp_lat);
        end
        do_req("withdraw_0", WDR, 0);
    endtask

    task automatic test_backpressure();
        int exp_lat, lat;
        resp_ready = 1'b0;
        send_req(INQ, 0, 1'b1, exp_lat);
        req_valid  = 1'b1;
        req_op     = DEP;
        req_amount = 10'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_status !== 2'b00 ||
                resp_balance !== model_balance[N-1:0]) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: vld=%b rdy=%b st=%b bal=%0d required 1 0 00 %0d",
                         i, resp_valid, req_ready, resp_status, resp_balance, model_balance);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        wait_resp(lat);
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release: vld=%b rdy=%b required 0 1", resp_valid, req_ready);
        end
        do_req("deposit_7_after_hold", DEP, 7);
    endtask

    task automatic test_back_to_back();
        do_req("b2b_first", DEP, 3);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: rdy=%b required 1", req_ready);
        end
        do_req("b2b_second", WDR, 5);
    endtask

    task automatic test_reset_abort();
        int dummy;
        send_req(WDR, 10, 1'b0, dummy);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_balance = 100;
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_balance !== INIT) begin
            miscompares++;
            $display("FAIL abort_state: vld=%b rdy=%b bal=%0d required 0 1 100",
                     resp_valid, req_ready, resp_balance);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (resp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_no_resp%0d: vld=%b required 0", i, resp_valid);
            end
        end
        do_req("inquiry_after_abort", INQ, 0);
        do_req("bad_op", BAD, 5);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_amount = '0;
        resp_ready = 1'b1;
        fork
            run_monitor();
        join_none
        test_reset();
        test_inquiry();
        test_deposit_withdraw();
        test_overflow();
        test_insufficient();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        repeat (2) @(posedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d responses outstanding required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
